// File: rtl/psum_accumulator_if.sv
// Result stream from psum_accumulator toward the output buffer / writeback.
// master drives data/valid, slave returns ready.
interface psum_accumulator_if #(
  parameter int ACC_WIDTH = 24
);
  logic signed [ACC_WIDTH-1:0] out_data;
  logic                        out_valid;
  logic                        out_ready;

  modport master (output out_data, output out_valid, input out_ready);
  modport slave  (input out_data, input out_valid, output out_ready);
endinterface

// File: rtl/psum_accumulator.sv
// Accumulates num_tiles adder-tree partial sums per output element, num_outs elements per job,
// into a small result FIFO. Optional macro PSUM_ACC_SATURATE_EN selects saturating accumulation.
module psum_accumulator #(
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 24,
  parameter int CNT_WIDTH  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         start,
  input  logic        [CNT_WIDTH-1:0]  num_tiles,
  input  logic        [CNT_WIDTH-1:0]  num_outs,
  input  logic signed [DATA_WIDTH-1:0] psum_in,
  input  logic                         psum_valid,
  psum_accumulator_if.master           res,
  output logic                         busy,
  output logic                         done,
  output logic                         overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [PTR_W:0]       PTR_ONE = (PTR_W+1)'(1);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state, state_nxt;

  logic        [CNT_WIDTH-1:0] tiles_m1, outs_m1, tile_cnt, out_cnt;
  logic signed [ACC_WIDTH-1:0] psum_ext, acc_p0, sum_p0, res_p1;
  logic                        vld_p1;
  logic                        last_tile, last_out, take_psum;
  logic signed [ACC_WIDTH-1:0] mem [FIFO_DEPTH];
  logic        [PTR_W:0]       wr_ptr, rd_ptr;
  logic                        fifo_empty, fifo_full, fifo_pop, fifo_push;

`ifdef PSUM_ACC_SATURATE_EN
  localparam logic signed [ACC_WIDTH-1:0] ACC_MAX = {1'b0, {(ACC_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH-1:0] ACC_MIN = {1'b1, {(ACC_WIDTH-1){1'b0}}};

  logic                      sat_p0, sat_hit_p0;
  logic signed [ACC_WIDTH:0] wide_p0;

  function automatic logic out_of_range(input logic signed [ACC_WIDTH:0] x);
    return x[ACC_WIDTH] != x[ACC_WIDTH-1];
  endfunction

  function automatic logic signed [ACC_WIDTH-1:0] saturate(input logic signed [ACC_WIDTH:0] x);
    if (!out_of_range(x)) return x[ACC_WIDTH-1:0];
    return x[ACC_WIDTH] ? ACC_MIN : ACC_MAX;
  endfunction
`endif

  assign psum_ext  = ACC_WIDTH'(psum_in);
  assign take_psum = (state == RUN) && psum_valid;
  assign last_tile = (tile_cnt == tiles_m1);
  assign last_out  = (out_cnt == outs_m1);

  // Stage p0: running sum of the current element
  always_comb begin
    sum_p0 = acc_p0 + psum_ext;
`ifdef PSUM_ACC_SATURATE_EN
    wide_p0    = {acc_p0[ACC_WIDTH-1], acc_p0} + {psum_ext[ACC_WIDTH-1], psum_ext};
    sat_hit_p0 = sat_p0 | out_of_range(wide_p0);
    // Once an element has clamped it stays clamped until it is pushed.
    sum_p0     = sat_p0 ? acc_p0 : saturate(wide_p0);
`endif
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (start) state_nxt = RUN;
      RUN:     if (take_psum && last_tile && last_out) state_nxt = DRAIN;
      DRAIN:   if (fifo_empty && !vld_p1) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state != IDLE);
    done = (state == DRAIN) && fifo_empty && !vld_p1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tiles_m1 <= '0;
      outs_m1  <= '0;
      acc_p0   <= '0;
      tile_cnt <= '0;
      out_cnt  <= '0;
      vld_p1   <= 1'b0;
      overflow <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
`ifdef PSUM_ACC_SATURATE_EN
      sat_p0   <= 1'b0;
`endif
    end else begin
      vld_p1 <= 1'b0;
      if ((state == IDLE) && start) begin
        tiles_m1 <= num_tiles - CNT_ONE;
        outs_m1  <= num_outs - CNT_ONE;
        acc_p0   <= '0;
        tile_cnt <= '0;
        out_cnt  <= '0;
        overflow <= 1'b0;
`ifdef PSUM_ACC_SATURATE_EN
        sat_p0   <= 1'b0;
`endif
      end else if (take_psum) begin
        if (last_tile) begin
          acc_p0   <= '0;
          tile_cnt <= '0;
          out_cnt  <= out_cnt + CNT_ONE;
          vld_p1   <= 1'b1;
`ifdef PSUM_ACC_SATURATE_EN
          sat_p0   <= 1'b0;
`endif
        end else begin
          acc_p0   <= sum_p0;
          tile_cnt <= tile_cnt + CNT_ONE;
`ifdef PSUM_ACC_SATURATE_EN
          sat_p0   <= sat_hit_p0;
`endif
        end
      end
      if (fifo_pop)  rd_ptr <= rd_ptr + PTR_ONE;
      if (fifo_push) wr_ptr <= wr_ptr + PTR_ONE;
      // A finished element with nowhere to go is lost; the job still counts it.
      if (vld_p1 && !fifo_push) overflow <= 1'b1;
    end
  end

  // Stage p1: finished element waiting to enter the FIFO
  always_ff @(posedge clk) begin
    if (take_psum && last_tile) res_p1 <= sum_p0;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                      (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign fifo_pop   = !fifo_empty && res.out_ready;
  assign fifo_push  = vld_p1 && (!fifo_full || fifo_pop);

  always_ff @(posedge clk) begin
    if (fifo_push) mem[wr_ptr[PTR_W-1:0]] <= res_p1;
  end

  assign res.out_valid = !fifo_empty;
  assign res.out_data  = fifo_empty ? '0 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_psum_accumulator.sv
// Directed bench for psum_accumulator: a 24-bit instance plus a 20-bit instance for the
// narrow-accumulator arithmetic case, both fed the same stimulus.
module tb_psum_accumulator;

  logic               clk = 1'b0;
  logic               rst_n;
  logic               start;
  logic        [7:0]  num_tiles, num_outs;
  logic signed [15:0] psum_in;
  logic               psum_valid;
  logic               out_ready;
  logic               busy, done, overflow;
  logic               busy_b, done_b, overflow_b;
  logic        [23:0] od;
  logic        [19:0] od20;

  int total = 0;
  int bad   = 0;

  psum_accumulator_if #(.ACC_WIDTH(24)) ri ();
  psum_accumulator_if #(.ACC_WIDTH(20)) ri20 ();

  assign ri.out_ready   = out_ready;
  assign ri20.out_ready = out_ready;
  assign od             = ri.out_data;
  assign od20           = ri20.out_data;

  always #5 clk = ~clk;

  psum_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(24), .CNT_WIDTH(8), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .num_outs(num_outs),
    .psum_in(psum_in), .psum_valid(psum_valid), .res(ri.master),
    .busy(busy), .done(done), .overflow(overflow)
  );

  psum_accumulator #(.DATA_WIDTH(16), .ACC_WIDTH(20), .CNT_WIDTH(8), .FIFO_DEPTH(4)) dut20 (
    .clk(clk), .rst_n(rst_n), .start(start), .num_tiles(num_tiles), .num_outs(num_outs),
    .psum_in(psum_in), .psum_valid(psum_valid), .res(ri20.master),
    .busy(busy_b), .done(done_b), .overflow(overflow_b)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic start_job(input logic [7:0] nt, input logic [7:0] no);
    start     = 1'b1;
    num_tiles = nt;
    num_outs  = no;
    step();
    start = 1'b0;
  endtask

  task automatic push(input logic signed [15:0] v);
    psum_in    = v;
    psum_valid = 1'b1;
    step();
    psum_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int n = 0;
    while (!done && n < 50) begin
      step();
      n++;
    end
    chk({tag, "_done"}, 32'(done), 32'd1);
    chk({tag, "_busy_at_done"}, 32'(busy), 32'd1);
    step();
    chk({tag, "_done_fall"}, 32'(done), 32'd0);
    chk({tag, "_busy_fall"}, 32'(busy), 32'd0);
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; start = 1'b0; num_tiles = '0; num_outs = '0;
    psum_in = '0; psum_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    chk("rst_valid",    32'(ri.out_valid), 32'd0);
    chk("rst_data",     32'(od),           32'd0);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_done",     32'(done),         32'd0);
    chk("rst_overflow", 32'(overflow),     32'd0);

    // Basic: 1+2+3+4 = 10, 10-20+30-40 = -20
    out_ready = 1'b1;
    start_job(8'd4, 8'd2);
    chk("basic_busy", 32'(busy), 32'd1);
    push(16'sd1); push(16'sd2); push(16'sd3); push(16'sd4);
    chk("basic_lat_a", 32'(ri.out_valid), 32'd0);
    push(16'sd10);
    chk("basic_valid_a", 32'(ri.out_valid), 32'd1);
    chk("basic_data_a",  32'(od),           32'h00000A);
    push(-16'sd20);
    chk("basic_popped_a", 32'(ri.out_valid), 32'd0);
    push(16'sd30); push(-16'sd40);
    chk("basic_lat_b", 32'(ri.out_valid), 32'd0);
    step();
    chk("basic_valid_b", 32'(ri.out_valid), 32'd1);
    chk("basic_data_b",  32'(od),           32'hFFFFEC);
    wait_done("basic");

    // Backpressure: FIFO keeps 1..4, 5 and 6 are dropped
    out_ready = 1'b0;
    start_job(8'd1, 8'd6);
    for (int i = 1; i <= 6; i++) begin
      push(16'(i));
      if (i >= 2) chk("bp_hold", 32'(od), 32'd1);
    end
    step();
    chk("bp_overflow", 32'(overflow),     32'd1);
    chk("bp_valid",    32'(ri.out_valid), 32'd1);
    chk("bp_head",     32'(od),           32'd1);
    chk("bp_no_done",  32'(done),         32'd0);
    out_ready = 1'b1;
    for (int i = 2; i <= 4; i++) begin
      step();
      chk("bp_pop", 32'(od), 32'(i));
    end
    step();
    chk("bp_empty", 32'(ri.out_valid), 32'd0);
    wait_done("bp");
    chk("bp_sticky", 32'(overflow), 32'd1);

    // Full FIFO with a pop on the same edge as the push
    out_ready = 1'b0;
    start_job(8'd1, 8'd5);
    chk("full_ovf_cleared", 32'(overflow), 32'd0);
    for (int i = 11; i <= 15; i++) push(16'(i));
    chk("full_head", 32'(od), 32'd11);
    out_ready = 1'b1;
    step();
    chk("full_no_ovf", 32'(overflow), 32'd0);
    for (int i = 12; i <= 15; i++) begin
      chk("full_order", 32'(od), 32'(i));
      step();
    end
    chk("full_empty", 32'(ri.out_valid), 32'd0);
    wait_done("full");
    chk("full_no_ovf_end", 32'(overflow), 32'd0);

    // 256 tiles of 0x7FFF
    start_job(8'd0, 8'd1);
    for (int i = 0; i < 256; i++) push(16'sh7FFF);
    chk("arith_lat", 32'(ri.out_valid), 32'd0);
    step();
    chk("arith_24", 32'(od), 32'h7FFF00);
`ifdef PSUM_ACC_SATURATE_EN
    chk("arith_20", 32'(od20), 32'h7FFFF);
`else
    chk("arith_20", 32'(od20), 32'hFFF00);
`endif
    wait_done("arith");

    // Reset mid-job
    start_job(8'd4, 8'd1);
    push(16'sd7); push(16'sd7);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_rst_valid", 32'(ri.out_valid), 32'd0);
    chk("mid_rst_busy",  32'(busy),         32'd0);
    chk("mid_rst_data",  32'(od),           32'd0);
    step();
    start_job(8'd4, 8'd1);
    push(16'sd5); push(16'sd5); push(16'sd5); push(16'sd5);
    step();
    chk("mid_rst_result", 32'(od), 32'd20);
    wait_done("mid_rst");

    // psum_valid in IDLE, start during RUN
    psum_in = 16'sd99; psum_valid = 1'b1;
    step(); step(); step();
    psum_valid = 1'b0;
    step();
    chk("idle_no_push", 32'(ri.out_valid), 32'd0);
    chk("idle_busy",    32'(busy),         32'd0);
    start_job(8'd2, 8'd2);
    push(16'sd3);
    start = 1'b1; num_tiles = 8'd1; num_outs = 8'd1;
    push(16'sd4);
    start = 1'b0;
    step();
    chk("idle_run_a", 32'(od), 32'd7);
    push(16'sd5); push(16'sd6);
    chk("idle_still_busy", 32'(busy), 32'd1);
    step();
    chk("idle_run_b", 32'(od), 32'd11);
    wait_done("idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
